// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-addressed memory,
// with read-modify-write for sub-word stores and alignment/range checking.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic [XLEN-1:0]     r_resp_rdata;
  logic                r_resp_err;
  logic                r_mem_write_en;
  logic [XLEN-1:0]     r_mem_addr;
  logic [XLEN-1:0]     r_mem_write_data;

  // latched request fields needed after accept
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [1:0]          r_addr_lo;
  logic [HALF_W-1:0]   r_wdata_lo;

  logic                w_accept;
  logic                w_f3_bad;
  logic                w_misalign;
  logic                w_range;
  logic                w_req_err;
  logic [BYTE_W-1:0]   w_byte;
  logic [HALF_W-1:0]   w_half;
  logic [XLEN-1:0]     w_load_data;
  logic [XLEN-1:0]     w_merged;
  logic                w_ld_addr;
  logic                w_ld_wdata;
  logic [XLEN-1:0]     w_wdata_nxt;
  logic [XLEN-1:0]     w_rdata_nxt;
  logic                w_err_nxt;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // request legality: funct3, natural alignment, 4096-word window
  always_comb begin
    w_f3_bad = 1'b0;
    if (req_we) begin
      w_f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      w_f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_range    = |req_addr[31:14];
    w_req_err  = w_f3_bad || w_misalign || w_range;
  end

  // lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    w_byte = mem_read_data[7:0];
    case (r_addr_lo)
      2'd0:    w_byte = mem_read_data[7:0];
      2'd1:    w_byte = mem_read_data[15:8];
      2'd2:    w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_addr_lo[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-HALF_W){w_half[HALF_W-1]}}, w_half};
      3'b100:  w_load_data = {{(XLEN-BYTE_W){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-HALF_W){1'b0}}, w_half};
      default: w_load_data = mem_read_data;
    endcase

    w_merged = mem_read_data;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr_lo)
        2'd0:    w_merged[7:0]   = r_wdata_lo[7:0];
        2'd1:    w_merged[15:8]  = r_wdata_lo[7:0];
        2'd2:    w_merged[23:16] = r_wdata_lo[7:0];
        default: w_merged[31:24] = r_wdata_lo[7:0];
      endcase
    end else if (r_addr_lo[1]) begin
      w_merged[31:16] = r_wdata_lo;
    end else begin
      w_merged[15:0] = r_wdata_lo;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_ld_addr   = 1'b0;
    w_ld_wdata  = 1'b0;
    w_wdata_nxt = r_mem_write_data;
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
          end else begin
            w_ld_addr = 1'b1;
            if (req_we && (req_funct3 == 3'b010)) begin
              w_state_nxt = S_WRITE;
              w_ld_wdata  = 1'b1;
              w_wdata_nxt = req_wdata;
            end else begin
              w_state_nxt = S_READ;
            end
          end
        end
      end
      S_READ:  w_state_nxt = S_MERGE;
      S_MERGE: begin
        if (r_we) begin
          w_state_nxt = S_WRITE;
          w_ld_wdata  = 1'b1;
          w_wdata_nxt = w_merged;
        end else begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = w_load_data;
        end
      end
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // registered outputs and latched request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= '0;
      r_resp_err       <= 1'b0;
      r_mem_write_en   <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
      r_we             <= 1'b0;
      r_funct3         <= '0;
      r_addr_lo        <= '0;
      r_wdata_lo       <= '0;
    end else begin
      r_req_ready    <= (w_state_nxt == S_IDLE);
      r_resp_valid   <= (w_state_nxt == S_RESP);
      r_mem_write_en <= (w_state_nxt == S_WRITE);
      if (w_accept) begin
        r_we       <= req_we;
        r_funct3   <= req_funct3;
        r_addr_lo  <= req_addr[1:0];
        r_wdata_lo <= req_wdata[HALF_W-1:0];
      end
      if (w_ld_addr) begin
        r_mem_addr <= {2'b00, req_addr[31:2]};
      end
      if (w_ld_wdata) begin
        r_mem_write_data <= w_wdata_nxt;
      end
      if (w_state_nxt == S_RESP) begin
        r_resp_rdata <= w_rdata_nxt;
        r_resp_err   <= w_err_nxt;
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;
  assign mem_write_en   = r_mem_write_en;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered word-memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'd0;

  logic [31:0] mem [0:4095];

  int total = 0;
  int bad   = 0;
  int wr_total   = 0;
  int resp_total = 0;

  load_store_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // registered-read word memory
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[11:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[11:0]];
  end

  // activity counters
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_en) begin
        wr_total++;
        check("wr_addr_hi", 32'(mem_addr[31:12]), 32'd0);
      end
      if (resp_valid) resp_total++;
    end
  end

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int wr);
    bit done;
    done = 1'b0; rd = '0; er = 1'b0; lat = 0; wr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_write_en) wr++;
      if (resp_valid) begin
        done = 1'b1; rd = resp_rdata; er = resp_err;
      end else begin
        lat++;
      end
    end
    check("resp_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, wr, rb, wb, pulses, last, cnt;
    logic [2:0]  ld_f3  [4];
    logic [31:0] ld_a   [4];
    logic [31:0] ld_exp [4];
    logic        e_we   [4];
    logic [2:0]  e_f3   [4];
    logic [31:0] e_a    [4];

    ld_f3  = '{3'b000, 3'b100, 3'b001, 3'b101};
    ld_a   = '{32'h13, 32'h13, 32'h10, 32'h12};
    ld_exp = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    e_we   = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_f3   = '{3'b010, 3'b001, 3'b000, 3'b011};
    e_a    = '{32'h2, 32'h1, 32'h00010000, 32'h10};

    // asynchronous reset, before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_we", 32'(mem_write_en), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_write_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // SW then LW
    do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, wr);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_wr", 32'(wr), 32'd1);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    do_op(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, wr);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_wr", 32'(wr), 32'd0);

    // sub-word loads with extension
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, ld_f3[i], ld_a[i], 32'd0, rd, er, lat, wr);
      check($sformatf("ld%0d_rdata", i), rd, ld_exp[i]);
      check($sformatf("ld%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("ld%0d_err", i), 32'(er), 32'd0);
    end

    // sub-word stores (read-modify-write)
    do_op(1'b1, 3'b000, 32'h11, 32'h12345678, rd, er, lat, wr);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_wr", 32'(wr), 32'd1);
    check("sb_err", 32'(er), 32'd0);
    check("sb_mem", mem[4], 32'hDEAD78EF);
    do_op(1'b1, 3'b001, 32'h12, 32'hAAAA5555, rd, er, lat, wr);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_wr", 32'(wr), 32'd1);
    check("sh_mem", mem[4], 32'h555578EF);

    // error requests
    wb = wr_total;
    for (int i = 0; i < 4; i++) begin
      do_op(e_we[i], e_f3[i], e_a[i], 32'hFFFFFFFF, rd, er, lat, wr);
      check($sformatf("err%0d_err", i), 32'(er), 32'd1);
      check($sformatf("err%0d_rdata", i), rd, 32'd0);
      check($sformatf("err%0d_lat", i), 32'(lat), 32'd0);
      check($sformatf("err%0d_wr", i), 32'(wr), 32'd0);
    end
    check("err_no_writes", 32'(wr_total - wb), 32'd0);
    check("err_mem", mem[4], 32'h555578EF);

    // req_valid held across three LWs
    rb = resp_total; wb = wr_total; pulses = 0; last = 0; cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    while (cnt < 40 && pulses < 3) begin
      @(negedge clk);
      if (resp_valid) begin
        pulses++;
        check($sformatf("b2b%0d_rdata", pulses), resp_rdata, 32'h555578EF);
        if (pulses > 1) check($sformatf("b2b%0d_gap", pulses), 32'(cnt - last), 32'd4);
        last = cnt;
      end
      cnt++;
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_pulses", 32'(resp_total - rb), 32'd3);
    check("b2b_no_writes", 32'(wr_total - wb), 32'd0);
    check("b2b_ready", 32'(req_ready), 32'd1);

    // reset during the write phase of an SB
    do_op(1'b1, 3'b010, 32'h14, 32'h11223344, rd, er, lat, wr);
    check("pre_rst_mem", mem[5], 32'h11223344);
    rb = resp_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h15; req_wdata = 32'h000000AB;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cnt = 0;
    while (cnt < 10 && !mem_write_en) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_wr_seen", 32'(mem_write_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_wr_drop", 32'(mem_write_en), 32'd0);
    check("rst_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_kept", mem[5], 32'h11223344);
    check("rst_resp_cnt", 32'(resp_total - rb), 32'd0);
    check("rst_ready_after", 32'(req_ready), 32'd1);
    do_op(1'b0, 3'b010, 32'h14, 32'd0, rd, er, lat, wr);
    check("post_rst_lw", rd, 32'h11223344);
    check("post_rst_lat", 32'(lat), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 req_valid  input  1  CPU request present.
REQ-004 req_ready  output  1  unit idle and able to accept; request accepted on a rising edge where req_valid && req_ready.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_funct3  input  3  RISC-V width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-011 resp_err  output  1  qualifies resp_valid: misaligned, out-of-range or illegal funct3.
REQ-012 mem_write_en  output  1  word-memory write enable.
REQ-013 mem_addr  output  32  word index to memory = {2'b00, addr[31:2]}.
REQ-014 mem_write_data  output  32  full word to write.
REQ-015 mem_read_data  input  32  registered memory output; valid the cycle after mem_addr was presented with mem_write_en=0.

Function
REQ-016 FSM states IDLE, READ, MERGE, WRITE, RESP; req_ready=1 only in IDLE; req_valid outside IDLE ignored, nothing latched.
REQ-017 On accept, addr/we/funct3/wdata latched; all later behaviour uses latched values only.
REQ-018 Error check at accept: illegal funct3 (loads 011/110/111, stores 011..111), halfword with addr[0]=1, word with addr[1:0]!=00, or addr[31:14]!=0 (beyond 4096 words) -> go to RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-019 IDLE transitions: valid load or SB/SH -> READ; valid SW -> WRITE (no read).
REQ-020 READ: mem_addr = latched word index, mem_write_en=0; next MERGE.
REQ-021 MERGE: mem_read_data valid; load -> select lane by addr[1:0] (byte) or addr[1] (half), sign-extend LB/LH, zero-extend LBU/LHU/pass LW, register into resp_rdata, next RESP; SB/SH -> register merged word replacing only addressed byte/half lanes of mem_read_data, next WRITE.
REQ-022 WRITE: mem_write_en=1 for exactly one cycle, mem_addr = word index, mem_write_data = req_wdata (SW) or merged word (SB/SH); next RESP.
REQ-023 RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err stable; next IDLE; resp_rdata/resp_err hold until next RESP.
REQ-024 Latency, accept edge = edge 0, resp_valid high in cycle after edge: error 0, SW 1, loads 2, SB/SH 3.
REQ-025 Back-to-back: next request accepted earliest on the edge ending the RESP-following IDLE cycle; no overlap of operations.
REQ-026 mem_write_en=0 in every state except WRITE; mem_addr/mem_write_data hold last values elsewhere.
REQ-027 Read-modify-write of SB/SH is atomic w.r.t. this unit; unit is sole memory master.

Reset
REQ-028 rst asserted: immediately (no clock) state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_en=0, mem_addr=0, mem_write_data=0.
REQ-029 rst mid-operation drops the operation with no response; rst during WRITE deasserts mem_write_en asynchronously so no partial write relies on that edge.
REQ-030 First request accepted no earlier than first rising edge after rst deasserts.

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem word 4 written once; LW resp_rdata=0xDEADBEEF, resp_err=0, latencies 1 and 2.
REQ-032 Word 4 = 0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-033 Word 4 = 0xDEADBEEF; SB 0x11 data 0x12345678 -> word 0xDEAD78EF; SH 0x12 data 0xAAAA5555 -> word 0x555578EF; mem_write_en one cycle each, latency 3.
REQ-034 LW 0x02, SH 0x01, LB 0x00010000, funct3 011 load -> each resp_err=1, resp_rdata=0, latency 0, mem_write_en never high, memory unchanged.
REQ-035 Assert rst in WRITE state of SB -> mem_write_en drops same cycle, no resp_valid, target word unchanged, req_ready=1 after release.
REQ-036 req_valid held high continuously across 3 LW requests -> each accepted only in IDLE, exactly 3 resp_valid pulses, no extra reads.
